exec_muldiv_unit: RTL and testbench

- Multi-cycle iterative multiply/divide unit for the RV32M extension. Runs alongside the single-cycle integer ALU in the execute stage.
- Accepts one operation at a time and raises busy so the controller stalls the execute stage and everything upstream.
- Returns a registered result with the destination register address and a one-cycle done pulse for the memory-access hand-off.
- Generalised over data width and multiplier bits-per-cycle; adds flush abort and RISC-V corner-case handling.

---
 rtl/exec_muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiply is a shift-add over a 2*XLEN accumulator (MUL_STEP bits per cycle),
// divide is restoring (one quotient bit per cycle). Divide-by-zero and signed
// overflow are resolved at accept and complete in a single cycle.
module exec_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      done_rd_addr
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int PW    = 2 * XLEN;
    localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(XLEN / MUL_STEP);
    localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  a_q, a_d;        // multiplicand or divisor (magnitude)
    logic [PW-1:0]    acc_q, acc_d;    // {product high, remaining multiplier}
    logic [XLEN:0]    rem_q, rem_d;    // partial remainder with next dividend bit appended
    logic [XLEN-1:0]  quo_q, quo_d;    // unconsumed dividend bits / quotient bits
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       done_rd_q, done_rd_d;

    logic            accept;
    logic            sgn1, sgn2, neg_in;
    logic [XLEN-1:0] abs1, abs2;
    logic            div0, ovf;
    logic [XLEN-1:0] spec_res;

    logic [XLEN+MUL_STEP-1:0] m_prod, m_sum;
    logic [PW-1:0]            acc_step, mul_fin;
    logic                     d_ge;
    logic [XLEN-1:0]          r_step;
    logic [XLEN-1:0]          quo_step, quo_fin, rem_fin;

    assign accept       = (state_q != S_CALC) && start && !flush;
    assign busy         = accept || ((state_q == S_CALC) && !flush);
    assign done         = done_q;
    assign result       = result_q;
    assign done_rd_addr = done_rd_q;

    // Operand preparation: signedness per op, magnitudes, result sign, special cases
    always_comb begin
        sgn1   = 1'b0;
        sgn2   = 1'b0;
        neg_in = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4: begin sgn1 = 1'b1; sgn2 = 1'b1; neg_in = rs1[XLEN-1] ^ rs2[XLEN-1]; end
            3'd2:             begin sgn1 = 1'b1; neg_in = rs1[XLEN-1]; end
            3'd6:             begin sgn1 = 1'b1; sgn2 = 1'b1; neg_in = rs1[XLEN-1]; end
            default:          ;
        endcase
        abs1 = (sgn1 && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2 = (sgn2 && rs2[XLEN-1]) ? -rs2 : rs2;
        div0 = funct3[2] && (rs2 == '0);
        ovf  = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        if (div0) spec_res = funct3[1] ? rs1 : '1;
        else      spec_res = funct3[1] ? '0  : rs1;
    end

    // One iteration of each datapath plus the sign-corrected final values
    always_comb begin
        m_prod   = {{MUL_STEP{1'b0}}, a_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
        m_sum    = {{MUL_STEP{1'b0}}, acc_q[PW-1:XLEN]} + m_prod;
        acc_step = PW'({m_sum, acc_q[XLEN-1:0]} >> MUL_STEP);
        mul_fin  = neg_q ? -acc_step : acc_step;

        d_ge     = rem_q >= {1'b0, a_q};
        r_step   = d_ge ? XLEN'(rem_q - {1'b0, a_q}) : rem_q[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], d_ge};
        quo_fin  = neg_q ? -quo_step : quo_step;
        rem_fin  = neg_q ? -r_step : r_step;
    end

    // Next-state / datapath control: flush wins, then accept, then iteration
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rd_d      = rd_q;
        a_d       = a_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        done_d    = 1'b0;
        result_d  = result_q;
        done_rd_d = done_rd_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_CALC: begin
                    cnt_d = cnt_q - 1'b1;
                    if (op_q[2]) begin
                        rem_d = {r_step, quo_q[XLEN-1]};
                        quo_d = quo_step;
                    end else begin
                        acc_d = acc_step;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = S_FIN;
                        done_d    = 1'b1;
                        done_rd_d = rd_q;
                        if (op_q[2])              result_d = op_q[1] ? rem_fin : quo_fin;
                        else if (op_q[1:0] == 2'd0) result_d = mul_fin[XLEN-1:0];
                        else                      result_d = mul_fin[PW-1:XLEN];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (start) begin
                        op_d  = funct3;
                        neg_d = neg_in;
                        rd_d  = rd_addr;
                        if (funct3[2]) begin
                            a_d   = abs2;
                            rem_d = {{XLEN{1'b0}}, abs1[XLEN-1]};
                            quo_d = {abs1[XLEN-2:0], 1'b0};
                            cnt_d = DIV_CYC;
                        end else begin
                            a_d   = abs1;
                            acc_d = {{XLEN{1'b0}}, abs2};
                            cnt_d = MUL_CYC;
                        end
                        if (div0 || ovf) begin
                            state_d   = S_FIN;
                            done_d    = 1'b1;
                            result_d  = spec_res;
                            done_rd_d = rd_addr;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rd_q      <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            done_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            done_q    <= done_d;
            result_q  <= result_d;
            done_rd_q <= done_rd_d;
        end
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// tb_exec_muldiv_unit: directed vectors against two instances (MUL_STEP 1 and 4).
// Stimulus pushes expected {result, rd, done cycle}; monitors pop on done.
module tb_exec_muldiv_unit;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_addr = '0;

    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;
    logic [4:0]  rdo1, rdo4;

    exp_t q1[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    exec_muldiv_unit #(.XLEN(32), .MUL_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd_addr(rd_addr), .busy(busy1), .done(done1),
        .result(res1), .done_rd_addr(rdo1)
    );

    exec_muldiv_unit #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd_addr(rd_addr), .busy(busy4), .done(done4),
        .result(res4), .done_rd_addr(rdo4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
        end
    endtask

    // Scoreboard monitor for the MUL_STEP=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected done: rd=%0d result=%h cycle %0d", rdo1, res1, cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1 result", res1, e.res);
                chk("dut1 rd", {27'd0, rdo1}, {27'd0, e.rd});
                chk("dut1 done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Scoreboard monitor for the MUL_STEP=4 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected done: rd=%0d result=%h cycle %0d", rdo4, res4, cyc);
            end else begin
                e = q4.pop_front();
                chk("dut4 result", res4, e.res);
                chk("dut4 rd", {27'd0, rdo4}, {27'd0, e.rd});
                chk("dut4 done cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; holds start for one cycle and returns at the next negedge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] ex,
                         input int l1, input int l4, input bit push);
        exp_t e;
        funct3 = f; rs1 = a; rs2 = b; rd_addr = rd; start = 1'b1;
        if (push) begin
            e.res = ex; e.rd = rd; e.cyc = cyc + l1; q1.push_back(e);
            e.cyc = cyc + l4; q4.push_back(e);
            last_res = ex; last_rd = rd;
        end
        #1;
        chk("dut1 busy on accept", {31'd0, busy1}, 32'd1);
        chk("dut4 busy on accept", {31'd0, busy4}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (q1.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        chk("pending ops drained", 32'(q1.size() + q4.size()), 32'd0);
        q1.delete();
        q4.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset done", {31'd0, done1}, 32'd0);
        chk("reset result", res1, 32'd0);
        chk("reset rd", {27'd0, rdo1}, 32'd0);
        chk("reset busy", {31'd0, busy1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // MUL with latency/busy profile on both step sizes
        issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, 9, 1'b1);  // returns at T+1
        repeat (7) @(negedge clk);                                             // T+8
        #1 chk("dut4 busy T+8", {31'd0, busy4}, 32'd1);
        @(negedge clk);                                                        // T+9
        #1 chk("dut4 busy in FIN", {31'd0, busy4}, 32'd0);
        repeat (23) @(negedge clk);                                            // T+32
        #1 chk("dut1 busy T+32", {31'd0, busy1}, 32'd1);
        @(negedge clk);                                                        // T+33
        #1 chk("dut1 busy in FIN", {31'd0, busy1}, 32'd0);
        wait_idle();

        issue(OP_MULH,   32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33, 9, 1'b1);
        wait_idle();
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33, 9, 1'b1);
        wait_idle();

        // MULHU then a DIVU started in dut1's FIN cycle
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 33, 9, 1'b1);
        repeat (32) @(negedge clk);                                            // T+33, FIN
        issue(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33, 33, 1'b1);
        wait_idle();

        issue(OP_DIV,  32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 33, 33, 1'b1);
        wait_idle();
        issue(OP_REM,  32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33, 33, 1'b1);
        wait_idle();
        issue(OP_REMU, 32'd100, 32'd7, 5'd7, 32'd2, 33, 33, 1'b1);
        wait_idle();

        // Special cases, issued back-to-back through FIN
        issue(OP_DIV,  32'h1234,     32'd0,        5'd8,  32'hFFFFFFFF, 1, 1, 1'b1);
        issue(OP_REMU, 32'h1234,     32'd0,        5'd10, 32'h1234,     1, 1, 1'b1);
        issue(OP_DIVU, 32'd55,       32'd0,        5'd11, 32'hFFFFFFFF, 1, 1, 1'b1);
        issue(OP_REM,  32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFF9, 1, 1, 1'b1);
        issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1, 1, 1'b1);
        issue(OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1, 1, 1'b1);
        wait_idle();

        // start during CALC is ignored
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 33, 33, 1'b1);
        repeat (5) @(negedge clk);
        funct3 = OP_DIVU; rs1 = 32'd5; rs2 = 32'd1; rd_addr = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // flush at T+10 of a DIV: no done, result held
        issue(OP_DIV, 32'd1000, 32'd3, 5'd15, 32'd0, 33, 33, 1'b0);
        repeat (9) @(negedge clk);                                             // T+10
        flush = 1'b1;
        @(negedge clk);                                                        // T+11
        flush = 1'b0;
        #1;
        chk("dut1 busy after flush", {31'd0, busy1}, 32'd0);
        chk("dut4 busy after flush", {31'd0, busy4}, 32'd0);
        repeat (40) @(negedge clk);
        chk("result held after flush", res1, last_res);
        chk("rd held after flush", {27'd0, rdo1}, {27'd0, last_rd});

        // start together with flush is dropped
        funct3 = OP_MUL; rs1 = 32'd3; rs2 = 32'd3; rd_addr = 5'd16; start = 1'b1; flush = 1'b1;
        #1 chk("busy with start+flush", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("busy after dropped start", {31'd0, busy1}, 32'd0);
        repeat (40) @(negedge clk);
        chk("result after dropped start", res1, last_res);

        // asynchronous reset mid-CALC
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd17, 32'd333, 33, 33, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst done", {31'd0, done1}, 32'd0);
        chk("async rst result", res1, 32'd0);
        chk("async rst rd", {27'd0, rdo1}, 32'd0);
        chk("async rst busy", {31'd0, busy1}, 32'd0);
        chk("async rst dut4 result", res4, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, 33, 33, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
